// File: rtl/energy_compress_calc_mc.sv
// Multi-channel compressor gain calculator: per-channel frame energy accumulation, sequential divide, dual AXIS output.
// Optional SAT_OUT_EN macro: saturate a/b to OUT_W bits instead of truncating.
module energy_compress_calc_mc #(
  parameter int ENRGY_W = 40,
  parameter int SUM_W   = 64,
  parameter int OUT_W   = 32,
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 25,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [31:0]        thresh,
  input  logic [15:0]        ratio,
  input  logic [CNT_W-1:0]   num_fft_pts,
  input  logic [ENRGY_W-1:0] s_axis_tdata,
  input  logic [CH_W-1:0]    s_axis_tid,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [OUT_W-1:0]   m_axis_a_tdata,
  output logic [CH_W-1:0]    m_axis_a_tid,
  output logic               m_axis_a_tvalid,
  input  logic               m_axis_a_tready,
  output logic [OUT_W-1:0]   m_axis_b_tdata,
  output logic [CH_W-1:0]    m_axis_b_tid,
  output logic               m_axis_b_tvalid,
  input  logic               m_axis_b_tready
);

  localparam int DC_W = $clog2(SUM_W + 1);
  localparam logic [CH_W:0] NUM_CH_V = NUM_CH[CH_W:0];

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, OUT = 2'd2} state_t;

  state_t             state_r, state_nx;
  logic [SUM_W-1:0]   sum_r [NUM_CH];
  logic [CNT_W-1:0]   cnt_r [NUM_CH];
  logic [SUM_W-1:0]   total_r, quo_r, rem_r;
  logic [31:0]        thresh_r;
  logic [15:0]        divisor_r;
  logic [CH_W-1:0]    ch_r;
  logic [DC_W-1:0]    div_cnt_r;
  logic               tready_r;
  logic               a_valid_r, b_valid_r;
  logic [OUT_W-1:0]   a_data_r, b_data_r;
  logic [CH_W-1:0]    a_tid_r, b_tid_r;

  logic [CNT_W-1:0]   n_m1_s;
  logic               ch_ok_s, accept_s, close_s;
  logic [SUM_W-1:0]   cur_sum_s, total_nx_s, dividend_s;
  logic [CNT_W-1:0]   cur_cnt_s;
  logic [SUM_W:0]     rem_sh_s, diff_s;
  logic [SUM_W+1:0]   thr_ext_s, a_sum_s, a_full_s;
  logic               compress_s;

  // Reduce a wide result to OUT_W bits, saturating when the option is built in.
  function automatic logic [OUT_W-1:0] reduce_out(input logic [SUM_W+1:0] v);
`ifdef SAT_OUT_EN
    if (v >= ((SUM_W+2)'(1) << OUT_W)) begin
      return {OUT_W{1'b1}};
    end else begin
      return OUT_W'(v);
    end
`else
    return OUT_W'(v);
`endif
  endfunction

  // Input beat decode, frame-close detection and divide datapath.
  always_comb begin
    n_m1_s     = (num_fft_pts == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : (num_fft_pts - CNT_W'(1));
    ch_ok_s    = ({1'b0, s_axis_tid} < NUM_CH_V);
    cur_sum_s  = {SUM_W{1'b0}};
    cur_cnt_s  = {CNT_W{1'b0}};
    if (ch_ok_s) begin
      cur_sum_s = sum_r[s_axis_tid];
      cur_cnt_s = cnt_r[s_axis_tid];
    end else begin
      cur_sum_s = {SUM_W{1'b0}};
      cur_cnt_s = {CNT_W{1'b0}};
    end
    accept_s   = s_axis_tvalid & tready_r & ch_ok_s;
    close_s    = accept_s & (cur_cnt_s >= n_m1_s);
    total_nx_s = cur_sum_s + {{(SUM_W-ENRGY_W){1'b0}}, s_axis_tdata};
    dividend_s = total_nx_s - {{(SUM_W-32){thresh[31]}}, thresh};
    rem_sh_s   = {rem_r, quo_r[SUM_W-1]};
    diff_s     = rem_sh_s - {{(SUM_W+1-16){1'b0}}, divisor_r};
    thr_ext_s  = {{(SUM_W+2-32){thresh_r[31]}}, thresh_r};
    compress_s = $signed({2'b00, total_r}) > $signed(thr_ext_s);
    a_sum_s    = {2'b00, quo_r} + thr_ext_s;
    if (!compress_s) begin
      a_full_s = {2'b00, total_r};
    end else if (a_sum_s[SUM_W+1]) begin
      a_full_s = {(SUM_W+2){1'b0}};
    end else begin
      a_full_s = a_sum_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (close_s) state_nx = DIV;
        else         state_nx = IDLE;
      end
      DIV: begin
        if (div_cnt_r == DC_W'(SUM_W)) state_nx = OUT;
        else                           state_nx = DIV;
      end
      OUT: begin
        if ((!a_valid_r || m_axis_a_tready) && (!b_valid_r || m_axis_b_tready)) state_nx = IDLE;
        else                                                                   state_nx = OUT;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, accumulators, divider and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r   <= IDLE;
      tready_r  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        sum_r[i] <= {SUM_W{1'b0}};
        cnt_r[i] <= {CNT_W{1'b0}};
      end
      total_r   <= {SUM_W{1'b0}};
      quo_r     <= {SUM_W{1'b0}};
      rem_r     <= {SUM_W{1'b0}};
      thresh_r  <= 32'd0;
      divisor_r <= 16'd1;
      ch_r      <= {CH_W{1'b0}};
      div_cnt_r <= {DC_W{1'b0}};
      a_valid_r <= 1'b0;
      b_valid_r <= 1'b0;
      a_data_r  <= {OUT_W{1'b0}};
      b_data_r  <= {OUT_W{1'b0}};
      a_tid_r   <= {CH_W{1'b0}};
      b_tid_r   <= {CH_W{1'b0}};
    end else begin
      state_r  <= state_nx;
      tready_r <= (state_nx == IDLE);
      case (state_r)
        IDLE: begin
          if (close_s) begin
            total_r              <= total_nx_s;
            quo_r                <= dividend_s;
            rem_r                <= {SUM_W{1'b0}};
            thresh_r             <= thresh;
            divisor_r            <= (ratio == 16'd0) ? 16'd1 : ratio;
            ch_r                 <= s_axis_tid;
            div_cnt_r            <= {DC_W{1'b0}};
            sum_r[s_axis_tid]    <= {SUM_W{1'b0}};
            cnt_r[s_axis_tid]    <= {CNT_W{1'b0}};
          end else if (accept_s) begin
            sum_r[s_axis_tid]    <= total_nx_s;
            cnt_r[s_axis_tid]    <= cur_cnt_s + CNT_W'(1);
          end
        end
        DIV: begin
          // Final cycle after SUM_W quotient steps: resolve compress/bypass and present outputs.
          if (div_cnt_r == DC_W'(SUM_W)) begin
            a_data_r  <= reduce_out(a_full_s);
            b_data_r  <= reduce_out({2'b00, total_r});
            a_tid_r   <= ch_r;
            b_tid_r   <= ch_r;
            a_valid_r <= 1'b1;
            b_valid_r <= 1'b1;
          end else begin
            if (!diff_s[SUM_W]) begin
              rem_r <= diff_s[SUM_W-1:0];
              quo_r <= {quo_r[SUM_W-2:0], 1'b1};
            end else begin
              rem_r <= rem_sh_s[SUM_W-1:0];
              quo_r <= {quo_r[SUM_W-2:0], 1'b0};
            end
            div_cnt_r <= div_cnt_r + DC_W'(1);
          end
        end
        OUT: begin
          if (a_valid_r && m_axis_a_tready) a_valid_r <= 1'b0;
          if (b_valid_r && m_axis_b_tready) b_valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign s_axis_tready   = tready_r;
  assign m_axis_a_tdata  = a_data_r;
  assign m_axis_a_tid    = a_tid_r;
  assign m_axis_a_tvalid = a_valid_r;
  assign m_axis_b_tdata  = b_data_r;
  assign m_axis_b_tid    = b_tid_r;
  assign m_axis_b_tvalid = b_valid_r;

endmodule
